array_processor_top: RTL and testbench



---
 rtl/array_processor_top.sv | 162 ++++++++++++++++
 tb/tb_array_processor_top.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/array_processor_top.sv
// SIMD array processor: one controller broadcasts a MIPS-style instruction to
// 2^SIZE lockstep PEs, each with a private 16-bit register file and host readback.
module array_processor_top #(
  parameter int unsigned SIZE   = 5,
  parameter int unsigned LENGTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic            start,
  input  logic [SIZE-1:0] PE_Addr,
  input  logic [9:0]      RegAddr,
  output logic [15:0]     data
);

  localparam int unsigned NUM_PE = 1 << SIZE;
  localparam int unsigned DW     = 16;
  localparam int unsigned RW     = 5;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t        r_state;
  logic          r_start;
  logic          r_start_d;
  logic [31:0]   r_instr;
  logic [DW-1:0] r_data;

  logic          w_rise;
  logic [5:0]    w_op;
  logic [RW-1:0] w_rs;
  logic [RW-1:0] w_rt;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_shamt;
  logic [3:0]    w_fn;
  logic [DW-1:0] w_imm;
  logic          w_wen;
  logic [RW-1:0] w_waddr;
  logic [DW-1:0] w_rd_val;

  logic [DW-1:0] w_pe_reg [NUM_PE];
  logic [DW-1:0] w_pe_res [NUM_PE];

  assign w_op    = r_instr[31:26];
  assign w_rs    = r_instr[25:21];
  assign w_rt    = r_instr[20:16];
  assign w_rd    = r_instr[15:11];
  assign w_shamt = r_instr[10:6];
  assign w_fn    = r_instr[3:0];
  assign w_imm   = r_instr[15:0];

  // R-type funct 0..7 writes rd; ADDI writes rt; everything else is a NOP
  assign w_wen   = ((w_op == 6'h00) && !w_fn[3]) || (w_op == 6'h08);
  assign w_waddr = (w_op == 6'h08) ? w_rt : w_rd;

  // Start edge detector resets "high" so a start held across reset release is not a rise
  assign w_rise  = r_start & ~r_start_d;

  function automatic logic [DW-1:0] f_alu(
    input logic [5:0]    op,
    input logic [3:0]    fn,
    input logic [RW-1:0] sh,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [DW-1:0] imm
  );
    f_alu = '0;
    if (op == 6'h08) begin
      f_alu = a + imm;
    end else begin
      case (fn)
        4'd0:    f_alu = a + b;
        4'd1:    f_alu = a - b;
        4'd2:    f_alu = a & b;
        4'd3:    f_alu = a | b;
        4'd4:    f_alu = a ^ b;
        4'd5:    f_alu = b << sh;
        4'd6:    f_alu = b >> sh;
        4'd7:    f_alu = a * b;
        default: f_alu = '0;
      endcase
    end
  endfunction

  // Controller: IDLE -> DECODE -> EXEC -> WB -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b1;
      r_start_d <= 1'b1;
      r_instr   <= '0;
    end else begin
      r_start   <= start;
      r_start_d <= r_start;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_instr <= instruction;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC:   r_state <= S_WB;
        S_WB:     r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    logic [LENGTH-1:0][DW-1:0] r_regs;
    logic [DW-1:0]             r_res;
    logic [DW-1:0]             r_opa;
    logic [DW-1:0]             r_opb;
    logic [DW-1:0]             r_alu;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned k = 0; k < LENGTH; k++) begin
          r_regs[k] <= DW'((32'(g) << 5) | k);
        end
        r_res <= '0;
        r_opa <= '0;
        r_opb <= '0;
        r_alu <= '0;
      end else begin
        case (r_state)
          S_DECODE: begin
            r_opa <= (32'(w_rs) < LENGTH) ? r_regs[w_rs] : '0;
            r_opb <= (32'(w_rt) < LENGTH) ? r_regs[w_rt] : '0;
          end
          S_EXEC: r_alu <= f_alu(w_op, w_fn, w_shamt, r_opa, r_opb, w_imm);
          S_WB: begin
            if (w_wen) begin
              r_res <= r_alu;
              if (32'(w_waddr) < LENGTH) r_regs[w_waddr] <= r_alu;
            end
          end
          default: ;
        endcase
      end
    end

    assign w_pe_reg[g] = (32'(RegAddr[4:0]) < LENGTH) ? r_regs[RegAddr[4:0]] : '0;
    assign w_pe_res[g] = r_res;
  end

  // Host readback mux
  always_comb begin
    w_rd_val = '0;
    if (RegAddr < 10'h020)       w_rd_val = w_pe_reg[PE_Addr];
    else if (RegAddr == 10'h020) w_rd_val = w_pe_res[PE_Addr];
    else if (RegAddr == 10'h021) w_rd_val = DW'(PE_Addr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_data <= '0;
    else        r_data <= w_rd_val;
  end

  assign data = r_data;

endmodule

// File: tb/tb_array_processor_top.sv
// Directed self-checking bench for array_processor_top.
module tb_array_processor_top;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        start;
  logic [9:0]  pe_bus;
  logic [9:0]  reg_addr;
  logic [15:0] data;

  int total;
  int bad;

  array_processor_top #(.SIZE(5), .LENGTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instr),
    .start       (start),
    .PE_Addr     (pe_bus[4:0]),
    .RegAddr     (reg_addr),
    .data        (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input logic [9:0] pe, input logic [9:0] ra,
                        input logic [15:0] exp, input string tag);
    @(negedge clk);
    pe_bus   = pe;
    reg_addr = ra;
    @(posedge clk);
    #1;
    check(tag, data, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic issue(input logic [31:0] ins);
    @(negedge clk);
    instr = ins;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    start    = 1'b0;
    instr    = '0;
    pe_bus   = '0;
    reg_addr = '0;

    // Reset readback
    do_reset();
    rd_chk(10'd17, 10'h004, 16'h0224, "rst_pe17_r4");
    rd_chk(10'd17, 10'h020, 16'h0000, "rst_pe17_res");
    rd_chk(10'd17, 10'h021, 16'h0011, "rst_pe17_idx");
    rd_chk(10'd0,  10'h000, 16'h0000, "rst_pe0_r0");

    // ADD r3 = r1 + r4 with exact latency check on PE 17
    @(negedge clk);
    pe_bus   = 10'd17;
    reg_addr = 10'h003;
    instr    = 32'h00241800;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("add_edge4_old", data, 16'h0223);
    @(posedge clk);
    #1;
    check("add_edge5_new", data, 16'h0445);
    repeat (4) @(posedge clk);
    rd_chk(10'd17, 10'h020, 16'h0445, "add_pe17_res");
    rd_chk(10'd0,  10'h003, 16'h0005, "add_pe0_r3");
    rd_chk(10'd31, 10'h003, 16'h07C5, "add_pe31_r3");

    // Level start: held high executes once per rise
    @(negedge clk);
    instr = 32'h00241800;
    start = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    instr = 32'h00240800;
    start = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    rd_chk(10'd0,  10'h001, 16'h0005, "lvl_pe0_r1");
    rd_chk(10'd17, 10'h001, 16'h0445, "lvl_pe17_r1");
    rd_chk(10'd0,  10'h003, 16'h0005, "lvl_pe0_r3");

    // ADDI / SUB / NOPs and the remaining ALU ops
    do_reset();
    issue(32'h2005FFFF);
    rd_chk(10'd2, 10'h005, 16'h003F, "addi_pe2_r5");
    rd_chk(10'd2, 10'h020, 16'h003F, "addi_pe2_res");
    issue(32'h00013001);
    rd_chk(10'd2, 10'h006, 16'hFFFF, "sub_pe2_r6");
    issue(32'hFC050000);
    rd_chk(10'd2, 10'h005, 16'h003F, "nop_op3f_r5");
    rd_chk(10'd2, 10'h020, 16'hFFFF, "nop_op3f_res");
    issue(32'h00003008);
    rd_chk(10'd2, 10'h006, 16'hFFFF, "nop_fn8_r6");
    issue(32'h00433807);
    rd_chk(10'd0,  10'h007, 16'h0006, "mul_pe0_r7");
    rd_chk(10'd1,  10'h007, 16'h04A6, "mul_pe1_r7");
    rd_chk(10'd17, 10'h007, 16'h8EA6, "mul_pe17_r7");
    issue(32'h00014105);
    rd_chk(10'd2, 10'h008, 16'h0410, "sll_pe2_r8");
    issue(32'h001F48C6);
    rd_chk(10'd31, 10'h009, 16'h007F, "srl_pe31_r9");
    issue(32'h00225004);
    rd_chk(10'd17, 10'h00A, 16'h0003, "xor_pe17_r10");
    issue(32'h00225803);
    rd_chk(10'd17, 10'h00B, 16'h0223, "or_pe17_r11");
    issue(32'h00226002);
    rd_chk(10'd17, 10'h00C, 16'h0220, "and_pe17_r12");

    // Address truncation and unmapped readback
    rd_chk(10'h271, 10'h004, 16'h0224, "trunc_pe_r4");
    rd_chk(10'h271, 10'h021, 16'h0011, "trunc_pe_idx");
    rd_chk(10'h271, 10'h3FF, 16'h0000, "ra_3ff");
    rd_chk(10'h271, 10'h022, 16'h0000, "ra_022");

    // Reset during EXEC discards the pending write
    @(negedge clk);
    instr = 32'h00241800;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_data", data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    rd_chk(10'd17, 10'h003, 16'h0223, "midrst_pe17_r3");
    rd_chk(10'd17, 10'h020, 16'h0000, "midrst_pe17_res");
    repeat (10) @(posedge clk);
    rd_chk(10'd17, 10'h003, 16'h0223, "midrst_idle_r3");

    // Start already high at reset release is not a rising edge
    @(negedge clk);
    start = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    rd_chk(10'd17, 10'h003, 16'h0223, "start_hi_rel_r3");
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    issue(32'h00241800);
    rd_chk(10'd17, 10'h003, 16'h0445, "post_rst_add_r3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
